motor_ppm_ctrl: RTL
===================

MOTOR_PPM_CTRL -- requirements
Module: motor_ppm_ctrl

Interface
REQ-001 Parameter FRAME_CYCLES, default 2251: clock cycles per PPM frame, matching the PPM output stage period.
REQ-002 Parameter ARM_FRAMES, default 50: consecutive frames ARM_REQ must be held to arm.
REQ-003 Parameter WDT_FRAMES, default 25: frames allowed without COMMIT while armed.
REQ-004 Parameter MAX_VAL, default 1000: upper clamp for throttle values.
REQ-005 Parameter SLEW_STEP, default 16: maximum per-frame increase per channel when slew limiting is compiled in.
REQ-006 CLK_1M  in  1  1 MHz system clock; the block has one clock, and reset is asynchronous and active-low.
REQ-007 RST_N  in  1  asynchronous active-low reset.
REQ-008 ARM_REQ  in  1  level arm request from the flight logic.
REQ-009 WR_EN  in  1  shadow-register write strobe.
REQ-010 WR_ADDR  in  2  channel select 0..3.
REQ-011 WR_DATA  in  10  throttle value, 0 = 1000 us pulse.
REQ-012 COMMIT  in  1  one-cycle strobe; applies the shadow set at the next frame boundary.
REQ-013 WR_READY  out  1  write/commit accepted this cycle.
REQ-014 VAL0..VAL3  out  10 each  per-motor values driving four PPM output stages.
REQ-015 FRAME_TICK  out  1  one-cycle pulse at the last cycle of each frame.
REQ-016 STATE  out  2  00 DISARMED, 01 ARMING, 10 ARMED, 11 FAILSAFE.

Function
REQ-017 Frame counter SHALL run 0..FRAME_CYCLES-1 and wrap; FRAME_TICK = 1 only when count = FRAME_CYCLES-1.
REQ-018 WR_READY SHALL be 1 in every cycle except the FRAME_TICK cycle; WR_EN and COMMIT with WR_READY = 0 SHALL be ignored.
REQ-019 An accepted write SHALL store min(WR_DATA, MAX_VAL) in shadow[WR_ADDR] one cycle later.
REQ-020 An accepted COMMIT SHALL set a pending flag; on FRAME_TICK in ARMED with pending set, VALn SHALL load shadow[n] (or the slewed value) in the following cycle and pending SHALL clear.
REQ-021 WR_EN and COMMIT in the same cycle: the write SHALL be included in the committed set.
REQ-022 State transitions SHALL be evaluated only on FRAME_TICK; VALn SHALL change only in the cycle after FRAME_TICK.
REQ-023 DISARMED: VALn = 0, and shadow and pending SHALL be cleared; ARM_REQ = 1 -> ARMING with the arm counter cleared.
REQ-024 ARMING: VALn = 0; ARM_REQ = 0 -> DISARMED; the arm counter increments per tick; reaching ARM_FRAMES -> ARMED.
REQ-025 ARMED: the watchdog counter SHALL clear on any frame with pending set, otherwise increment; reaching WDT_FRAMES -> FAILSAFE; ARM_REQ = 0 -> DISARMED (this takes priority over the watchdog).
REQ-026 FAILSAFE: VALn SHALL be forced to 0 immediately at the tick; the only exit is ARM_REQ = 0 -> DISARMED.
REQ-027 Counters SHALL saturate, never wrap.

Reset
REQ-028 While RST_N = 0: STATE = DISARMED, VALn = 0, shadows = 0, pending = 0, FRAME_TICK = 0, WR_READY = 0, and all counters = 0.
REQ-029 Reset mid-frame SHALL restart the frame at count 0 after release; WR_READY = 1 from the first clock after release.

Configuration
REQ-030 Macro MOTOR_SLEW_LIMIT_EN defined: on each commit, increases SHALL be limited to SLEW_STEP per frame, and the remainder continues on later ticks without a new COMMIT; decreases and forced-zero SHALL apply at once.
REQ-031 Macro undefined: VALn SHALL jump to the committed value; SLEW_STEP is unused.

Structure
REQ-032 The state encoding, channel count (4), and FRAME_CYCLES/MAX_VAL defaults SHALL reside in shared package motor_pkg.
REQ-033 The frame counter and tick generation SHALL be sub-module ppm_frame_timer; all other logic is in motor_ppm_ctrl.

Verification
REQ-034 Hold ARM_REQ = 1 -> STATE 01 after the first tick, and 10 after 50 ticks; dropping ARM_REQ at tick 30 -> 00.
REQ-035 ARMED: write ch2 = 500, COMMIT mid-frame -> VAL2 = 500 in the cycle after the next FRAME_TICK, with other channels unchanged.
REQ-036 Write ch0 = 1023 -> VAL0 = 1000 after commit; WR_EN on the FRAME_TICK cycle is ignored.
REQ-037 ARMED with no COMMIT for 25 ticks -> STATE 11 and VALn = 0; ARM_REQ = 0 -> 00; re-arm requires 50 more ticks.
REQ-038 MOTOR_SLEW_LIMIT_EN: commit 0 -> 100 -> VAL0 = 16, 32, … 96, then 100 on successive ticks; commit 10 -> VAL0 = 10 next tick.
REQ-039 Assert RST_N = 0 mid-frame with VAL = 700 -> VALn = 0 and STATE = 00 immediately; the first FRAME_TICK occurs FRAME_CYCLES cycles after release.

Source files
------------

// File: rtl/motor_pkg.sv
// motor_pkg: shared constants, state codes and helper functions for the
// four-channel motor PPM controller.
package motor_pkg;

    localparam int NUM_CH           = 4;
    localparam int VAL_W            = 10;
    localparam int FRAME_CYCLES_DEF = 2251;
    localparam int MAX_VAL_DEF      = 1000;
    localparam int CNT_W            = 16;

    localparam logic [1:0] ST_DISARMED = 2'b00;
    localparam logic [1:0] ST_ARMING   = 2'b01;
    localparam logic [1:0] ST_ARMED    = 2'b10;
    localparam logic [1:0] ST_FAILSAFE = 2'b11;

    typedef logic [VAL_W-1:0]  val_t;
    typedef val_t [NUM_CH-1:0] val_vec_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Limit a throttle write to the configured ceiling.
    function automatic val_t clamp_val(val_t d, int max_v);
        return (int'(d) > max_v) ? val_t'(max_v) : d;
    endfunction

    // One slew step toward the goal: decreases land at once, increases by at most step.
    function automatic val_t slew_next(val_t cur, val_t tgt, int step);
        if (tgt <= cur)
            return tgt;
        if (int'(tgt) - int'(cur) > step)
            return cur + val_t'(step);
        return tgt;
    endfunction

    // Saturating increment; frame counters must never wrap.
    function automatic cnt_t sat_inc(cnt_t c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/motor_ppm_ctrl_if.sv
// motor_ppm_ctrl_if: flight-logic side bus of the motor controller
// (arm request, shadow write port, commit strobe, motor values and status).
interface motor_ppm_ctrl_if;

    logic                ARM_REQ;
    logic                WR_EN;
    logic [1:0]          WR_ADDR;
    motor_pkg::val_t     WR_DATA;
    logic                COMMIT;
    logic                WR_READY;
    motor_pkg::val_t     VAL0;
    motor_pkg::val_t     VAL1;
    motor_pkg::val_t     VAL2;
    motor_pkg::val_t     VAL3;
    logic                FRAME_TICK;
    logic [1:0]          STATE;

    modport master (
        output ARM_REQ, WR_EN, WR_ADDR, WR_DATA, COMMIT,
        input  WR_READY, VAL0, VAL1, VAL2, VAL3, FRAME_TICK, STATE
    );

    modport slave (
        input  ARM_REQ, WR_EN, WR_ADDR, WR_DATA, COMMIT,
        output WR_READY, VAL0, VAL1, VAL2, VAL3, FRAME_TICK, STATE
    );

endinterface

// File: rtl/motor_ppm_ctrl_frame_timer.sv
// ppm_frame_timer: free-running frame counter 0..FRAME_CYCLES-1 with a
// one-cycle tick on the last cycle of every frame. Reset restarts the frame.
module ppm_frame_timer #(
    parameter int FRAME_CYCLES = motor_pkg::FRAME_CYCLES_DEF
) (
    input  logic CLK_1M,
    input  logic RST_N,
    output logic o_tick
);

    localparam int              CW   = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST = CW'(FRAME_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Count cycles within the frame and wrap on the last one.
    always_ff @(posedge CLK_1M or negedge RST_N) begin
        if (!RST_N)
            r_cnt <= '0;
        else if (r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/motor_ppm_ctrl.sv
// motor_ppm_ctrl: arming/failsafe state machine, shadow throttle registers
// and frame-synchronous update of four motor values.
// Optional feature: define MOTOR_SLEW_LIMIT_EN to limit per-frame increases
// to SLEW_STEP; otherwise values jump straight to the committed set.
module motor_ppm_ctrl
    import motor_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int ARM_FRAMES   = 50,
    parameter int WDT_FRAMES   = 25,
    parameter int MAX_VAL      = MAX_VAL_DEF,
    parameter int SLEW_STEP    = 16
) (
    input  logic             CLK_1M,
    input  logic             RST_N,
    motor_ppm_ctrl_if.slave  bus
);

`ifdef MOTOR_SLEW_LIMIT_EN
    localparam int STEP = SLEW_STEP;
`else
    // Every change lands in one tick: the step covers at least the whole value range.
    localparam int STEP = (SLEW_STEP > (1 << VAL_W)) ? SLEW_STEP : (1 << VAL_W);
`endif

    logic        w_tick;
    logic        r_rdy;
    logic        w_ready;
    logic        w_wr_acc;
    logic        w_cm_acc;
    logic [1:0]  r_state;
    logic        r_pending;
    cnt_t        r_arm_cnt;
    cnt_t        r_wdt_cnt;
    cnt_t        w_arm_nxt;
    cnt_t        w_wdt_nxt;
    val_vec_t    r_shadow;
    val_vec_t    r_val;
    val_vec_t    r_tgt;
    val_vec_t    w_goal;
    val_vec_t    w_slewed;

    ppm_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_timer (
        .CLK_1M (CLK_1M),
        .RST_N  (RST_N),
        .o_tick (w_tick)
    );

    // Write port is closed during reset, the first partial cycle and the tick cycle.
    always_ff @(posedge CLK_1M or negedge RST_N) begin
        if (!RST_N)
            r_rdy <= 1'b0;
        else
            r_rdy <= 1'b1;
    end

    assign w_ready  = r_rdy & ~w_tick;
    assign w_wr_acc = w_ready & bus.WR_EN;
    assign w_cm_acc = w_ready & bus.COMMIT;

    // Shadow set and commit flag; DISARMED keeps both cleared.
    always_ff @(posedge CLK_1M or negedge RST_N) begin
        if (!RST_N) begin
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else if (r_state == ST_DISARMED) begin
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_shadow[bus.WR_ADDR] <= clamp_val(bus.WR_DATA, MAX_VAL);
            if (w_cm_acc)
                r_pending <= 1'b1;
            else if (w_tick && r_state == ST_ARMED)
                r_pending <= 1'b0;
        end
    end

    // A fresh commit retargets the channels; otherwise keep walking toward the old target.
    assign w_goal    = r_pending ? r_shadow : r_tgt;
    assign w_arm_nxt = sat_inc(r_arm_cnt);
    assign w_wdt_nxt = sat_inc(r_wdt_cnt);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slew
        assign w_slewed[g] = slew_next(r_val[g], w_goal[g], STEP);
    end

    // Frame-synchronous state machine and motor value update.
    always_ff @(posedge CLK_1M or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_DISARMED;
            r_arm_cnt <= '0;
            r_wdt_cnt <= '0;
            r_val     <= '0;
            r_tgt     <= '0;
        end else if (w_tick) begin
            case (r_state)
                ST_DISARMED: begin
                    if (bus.ARM_REQ) begin
                        r_state   <= ST_ARMING;
                        r_arm_cnt <= '0;
                    end
                end
                ST_ARMING: begin
                    // The entry tick counts as the first held frame, so arm after ARM_FRAMES-1 more.
                    if (!bus.ARM_REQ) begin
                        r_state <= ST_DISARMED;
                    end else begin
                        r_arm_cnt <= w_arm_nxt;
                        if (int'(w_arm_nxt) >= ARM_FRAMES - 1) begin
                            r_state   <= ST_ARMED;
                            r_wdt_cnt <= '0;
                            r_val     <= '0;
                            r_tgt     <= '0;
                        end
                    end
                end
                ST_ARMED: begin
                    if (!bus.ARM_REQ) begin
                        r_state <= ST_DISARMED;
                        r_val   <= '0;
                        r_tgt   <= '0;
                    end else if (r_pending) begin
                        r_wdt_cnt <= '0;
                        r_tgt     <= r_shadow;
                        r_val     <= w_slewed;
                    end else if (int'(w_wdt_nxt) >= WDT_FRAMES) begin
                        r_state   <= ST_FAILSAFE;
                        r_wdt_cnt <= w_wdt_nxt;
                        r_val     <= '0;
                        r_tgt     <= '0;
                    end else begin
                        r_wdt_cnt <= w_wdt_nxt;
                        r_val     <= w_slewed;
                    end
                end
                default: begin
                    if (!bus.ARM_REQ)
                        r_state <= ST_DISARMED;
                end
            endcase
        end
    end

    assign bus.WR_READY   = w_ready;
    assign bus.FRAME_TICK = w_tick;
    assign bus.STATE      = r_state;
    assign bus.VAL0       = r_val[0];
    assign bus.VAL1       = r_val[1];
    assign bus.VAL2       = r_val[2];
    assign bus.VAL3       = r_val[3];

endmodule
